// File: rtl/lru_pkg.sv
// Shared types and constants for the 4-line true-LRU replacement tracker.
// Ages: 0 is most recently used, LINES-1 is least recently used.
package lru_pkg;
  localparam int LINES = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 16;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W-1:0] age_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Reset ordering leaves line 0 as LRU and line LINES-1 as MRU.
  function automatic age_t reset_age(input int i);
    return age_t'(LINES - 1 - i);
  endfunction
endpackage

// File: rtl/lru_tracker_if.sv
// Access/perf bundle between the cache line-select logic (master) and the LRU tracker (slave).
interface lru_tracker_if;
  import lru_pkg::*;

  logic access_valid;
  idx_t access_line;
  logic access_hit;
  logic flush;
  idx_t lru_line;
  logic all_valid;
  cnt_t hit_count;
  cnt_t miss_count;

  modport master (
    output access_valid, access_line, access_hit, flush,
    input  lru_line, all_valid, hit_count, miss_count
  );

  modport slave (
    input  access_valid, access_line, access_hit, flush,
    output lru_line, all_valid, hit_count, miss_count
  );
endinterface

// File: rtl/lru_victim_sel.sv
// Victim choice from registered line state: lowest-index invalid line first,
// otherwise the line holding the oldest age.
module lru_victim_sel
  import lru_pkg::*;
(
  input  logic [LINES-1:0] valid_i,
  input  age_t             age_i [LINES],
  output idx_t             lru_line_o,
  output logic             all_valid_o
);

  logic [LINES-1:0] is_oldest;
  logic             full;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_oldest
      assign is_oldest[gi] = (age_i[gi] == age_t'(LINES - 1));
    end
  endgenerate

  assign full        = &valid_i;
  assign all_valid_o = full;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    lru_line_o = '0;
    if (full) begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (is_oldest[i]) lru_line_o = idx_t'(i);
      end
    end else begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (!valid_i[i]) lru_line_o = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/lru_tracker.sv
// Replacement-state keeper for the 4-line fully-associative cache: valid bits,
// true-LRU ages, victim output and saturating hit/miss counters.
module lru_tracker
  import lru_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  lru_tracker_if.slave bus
);

  logic [LINES-1:0] valid_q, valid_d;
  age_t             age_q [LINES];
  age_t             age_d [LINES];
  cnt_t             hit_q, hit_d;
  cnt_t             miss_q, miss_d;
  age_t             acc_age;
  logic             do_access;

  // Flush takes priority: a colliding access is dropped entirely.
  assign do_access = bus.access_valid && !bus.flush;
  assign acc_age   = age_q[bus.access_line];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic hit_this;
      logic younger;
      assign hit_this = (bus.access_line == idx_t'(gi));
      assign younger  = (age_q[gi] < acc_age);

      assign age_d[gi] = bus.flush               ? reset_age(gi) :
                         !do_access              ? age_q[gi] :
                         hit_this                ? age_t'(0) :
                         younger                 ? age_t'(age_q[gi] + 1'b1) :
                                                   age_q[gi];

      assign valid_d[gi] = bus.flush ? 1'b0 :
                           (do_access && hit_this) ? 1'b1 : valid_q[gi];
    end
  endgenerate

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (do_access) begin
      if (bus.access_hit) begin
        if (hit_q != '1) hit_d = hit_q + 1'b1;
      end else begin
        if (miss_q != '1) miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      for (int i = 0; i < LINES; i++) age_q[i] <= reset_age(i);
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      for (int i = 0; i < LINES; i++) age_q[i] <= age_d[i];
    end
  end

  lru_victim_sel u_victim_sel (
    .valid_i     (valid_q),
    .age_i       (age_q),
    .lru_line_o  (bus.lru_line),
    .all_valid_o (bus.all_valid)
  );

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

endmodule
